// File: rtl/tns_link_scheduler.sv
// rtl/tns_link_scheduler.sv - two-requester round-robin link scheduler feeding a shared TNS encoder
//
// Ports:
//   clock, rst            sole rising-edge clock, synchronous active-high reset
//   en                    issue enable; 0 freezes FIFO pops, arbitration keeps filling
//   req0_valid/data/ready requester 0 word offer and accept strobe
//   req1_valid/data/ready requester 1 word offer and accept strobe
//   enc_datain            registered word driven to the shared encoder
//   enc_rst_n             encoder reset, combinational ~rst
//   enc_codeout           encoder registered code output
//   code_out              enc_codeout passed through
//   code_valid, code_src  tag of the word currently on code_out
//   fifo_level            current issue-FIFO occupancy
//
// Build option: TNS_LINK_IDLE_HOLD_EN
//   defined   -> enc_datain holds its last value on cycles with no pop
//   undefined -> enc_datain is loaded with 0 on cycles with no pop

`ifndef BLEN05
`define BLEN05 5
`endif

module tns_link_scheduler #(
    parameter int DW    = `BLEN05,
    parameter int BURST = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     req0_valid,
    input  logic [DW-1:0]            req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [DW-1:0]            req1_data,
    output logic                     req1_ready,
    output logic [DW-1:0]            enc_datain,
    output logic                     enc_rst_n,
    input  logic [14:0]              enc_codeout,
    output logic [14:0]              code_out,
    output logic                     code_valid,
    output logic                     code_src,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BURST + 1);

    // FIFO entry: {src, data}
    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          owner;       // last requester that won a transfer
    logic [CW-1:0] burst_cnt;   // consecutive accepts of owner
    logic          grant;
    logic          full;
    logic          push;
    logic          pop;
    logic          owner_valid;
    logic [DW:0]   head;

    logic          tag1_valid;
    logic          tag1_src;

    // Full is taken from registered occupancy only, so a pop in the same
    // cycle never opens a slot for a push.
    assign full        = (count == (AW + 1)'(DEPTH));
    assign pop         = en && (count != '0);
    assign head        = mem[rd_ptr];
    assign owner_valid = owner ? req1_valid : req0_valid;

    always_comb begin
        grant = owner;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req0_valid && req1_valid && (burst_cnt >= CW'(BURST))) begin
            grant = ~owner;
        end
    end

    assign req0_ready = !rst && !full && !grant && req0_valid;
    assign req1_ready = !rst && !full &&  grant && req1_valid;
    assign push       = req0_ready || req1_ready;

    assign enc_rst_n  = ~rst;
    assign code_out   = enc_codeout;
    assign fifo_level = count;

    // Storage is not reset; pointers and occupancy define what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {grant, grant ? req1_data : req0_data};
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            owner      <= 1'b0;
            burst_cnt  <= '0;
            enc_datain <= '0;
            tag1_valid <= 1'b0;
            tag1_src   <= 1'b0;
            code_valid <= 1'b0;
            code_src   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            // An owner change restarts the run, and the accept that caused
            // it is the first of the new run. The count saturates at BURST
            // while a lone requester streams.
            if (push) begin
                if (grant == owner) begin
                    if (burst_cnt < CW'(BURST)) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end else begin
                    owner     <= grant;
                    burst_cnt <= CW'(1);
                end
            end else if (!owner_valid) begin
                burst_cnt <= '0;
            end

            if (pop) begin
                enc_datain <= head[DW-1:0];
            end else begin
`ifdef TNS_LINK_IDLE_HOLD_EN
                enc_datain <= enc_datain;
`else
                enc_datain <= '0;
`endif
            end

            // Tag stage 1 lines up with enc_datain, stage 2 with enc_codeout.
            tag1_valid <= pop;
            tag1_src   <= pop && head[DW];
            code_valid <= tag1_valid;
            code_src   <= tag1_src;
        end
    end

endmodule

// File: tb/tb_tns_link_scheduler.sv
// tb/tb_tns_link_scheduler.sv - self-checking bench for tns_link_scheduler

module tb_tns_link_scheduler;

    localparam int DW    = 5;
    localparam int BURST = 2;
    localparam int DEPTH = 4;

    logic            clock = 1'b0;
    logic            rst;
    logic            en;
    logic            req0_valid;
    logic [DW-1:0]   req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [DW-1:0]   req1_data;
    logic            req1_ready;
    logic [DW-1:0]   enc_datain;
    logic            enc_rst_n;
    logic [14:0]     enc_codeout;
    logic [14:0]     code_out;
    logic            code_valid;
    logic            code_src;
    logic [2:0]      fifo_level;

    always #5 clock = ~clock;

    tns_link_scheduler #(.DW(DW), .BURST(BURST), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .rst         (rst),
        .en          (en),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .enc_datain  (enc_datain),
        .enc_rst_n   (enc_rst_n),
        .enc_codeout (enc_codeout),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .code_src    (code_src),
        .fifo_level  (fifo_level)
    );

    function automatic logic [14:0] enc_f(input logic [DW-1:0] d);
        return 15'(d) * 15'd7 + 15'd3;
    endfunction

    // Stand-in encoder: registered code of the word it was given.
    always @(posedge clock) begin
        if (!enc_rst_n) enc_codeout <= '0;
        else            enc_codeout <= enc_f(enc_datain);
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model
    typedef struct { bit v; bit s; } tag_t;
    logic [DW:0]     mq[$];
    tag_t            tq[$];
    bit              m_owner;
    int              m_run;
    logic [DW-1:0]   m_enc;
    logic [14:0]     m_code;

    bit              ob_a0, ob_a1, ob_cv, ob_src, ob_rn;
    logic [DW-1:0]   ob_enc;
    int              ob_lvl;

    task automatic reset_model();
        mq.delete();
        tq.delete();
        tq.push_back('{0, 0});
        tq.push_back('{0, 0});
        m_owner = 0;
        m_run   = 0;
        m_enc   = '0;
        m_code  = '0;
    endtask

    // Called at a falling edge; drives one cycle, checks it, returns at the next falling edge.
    task automatic step(input bit r, input bit e, input bit v0, input logic [DW-1:0] d0,
                        input bit v1, input logic [DW-1:0] d1);
        bit g, full, e0, e1, pop;
        logic [DW:0] head;
        rst = r; en = e;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        #1;
        full = (mq.size() == DEPTH);
        if (v0 && !v1)      g = 0;
        else if (v1 && !v0) g = 1;
        else if (v0 && v1)  g = (m_run >= BURST) ? !m_owner : m_owner;
        else                g = m_owner;
        e0 = !r && !full && v0 && !g;
        e1 = !r && !full && v1 && g;
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("fifo_level", fifo_level, mq.size());
        check("enc_datain", enc_datain, m_enc);
        check("code_valid", code_valid, tq[0].v);
        check("code_src",   code_src,   tq[0].s);
        check("code_out",   code_out,   m_code);
        check("enc_rst_n",  enc_rst_n,  !r);
        ob_a0 = req0_ready; ob_a1 = req1_ready; ob_cv = code_valid;
        ob_src = code_src; ob_enc = enc_datain; ob_lvl = int'(fifo_level); ob_rn = enc_rst_n;
        @(posedge clock);
        cyc++;
        if (r) begin
            reset_model();
        end else begin
            m_code = enc_f(m_enc);
            pop = e && (mq.size() > 0);
            head = '0;
            if (pop) head = mq.pop_front();
            tq.push_back('{pop, pop && head[DW]});
            void'(tq.pop_front());
            if (pop) m_enc = head[DW-1:0];
            else begin
`ifndef TNS_LINK_IDLE_HOLD_EN
                m_enc = '0;
`endif
            end
            if (e0 || e1) begin
                mq.push_back({g, g ? d1 : d0});
                if (g == m_owner) m_run++;
                else begin
                    m_owner = g;
                    m_run   = 1;
                end
            end else if (!(m_owner ? v1 : v0)) begin
                m_run = 0;
            end
        end
        @(negedge clock);
    endtask

    typedef struct {
        bit            en;
        bit            v0;
        bit            v1;
        logic [DW-1:0] d;
        bit            r0;
        bit            r1;
        int            lvl;
    } vec_t;

    vec_t tbl[10];
    bit   cv_h[6];
    logic [DW-1:0] enc_h[6];

    initial begin
        int  cv_cnt;
        logic [5:0] exp_order;

        rst = 1; en = 0;
        req0_valid = 0; req0_data = '0; req1_valid = 0; req1_data = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_model();

        // Two words from requester 0, encoder alignment
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 5'd1, 0, 0);
        check("s1_accept0", ob_a0, 1);
        step(0, 1, 1, 5'd2, 0, 0);
        check("s1_accept1", ob_a0, 1);
        for (int k = 2; k < 6; k++) begin
            step(0, 1, 0, 0, 0, 0);
            cv_h[k] = ob_cv;
            enc_h[k] = ob_enc;
            if (ob_cv) check("s1_src", ob_src, 0);
        end
        check("s1_enc_c2", enc_h[2], 1);
        check("s1_enc_c3", enc_h[3], 2);
        check("s1_cv_c2", cv_h[2], 0);
        check("s1_cv_c3", cv_h[3], 1);
        check("s1_cv_c4", cv_h[4], 1);
        check("s1_cv_c5", cv_h[5], 0);

        // Both valid continuously: burst of 2 then hand over
        step(1, 0, 0, 0, 0, 0);
        exp_order = 6'b001100;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 5'(i), 1, 5'(i + 8));
            check("s2_one_accept", ob_a0 ^ ob_a1, 1);
            check("s2_order", ob_a1, exp_order[5 - i]);
        end
        repeat (3) step(0, 1, 0, 0, 0, 0);

        // Fill with en=0, then single-cycle pops with pending pushes
        tbl[0] = '{0, 1, 0, 5'd1, 1, 0, 0};
        tbl[1] = '{0, 1, 0, 5'd2, 1, 0, 1};
        tbl[2] = '{0, 1, 0, 5'd3, 1, 0, 2};
        tbl[3] = '{0, 1, 0, 5'd4, 1, 0, 3};
        tbl[4] = '{0, 1, 0, 5'd5, 0, 0, 4};
        tbl[5] = '{1, 1, 0, 5'd5, 0, 0, 4};
        tbl[6] = '{0, 1, 0, 5'd5, 1, 0, 3};
        tbl[7] = '{1, 0, 1, 5'd9, 0, 0, 4};
        tbl[8] = '{0, 0, 1, 5'd9, 0, 1, 3};
        tbl[9] = '{0, 0, 0, 5'd0, 0, 0, 4};
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].en, tbl[i].v0, tbl[i].d, tbl[i].v1, tbl[i].d);
            check("tbl_r0", ob_a0, tbl[i].r0);
            check("tbl_r1", ob_a1, tbl[i].r1);
            check("tbl_lvl", ob_lvl, tbl[i].lvl);
        end
        repeat (6) step(0, 1, 0, 0, 0, 0);

        // Ten words through the FIFO with pointer wrap
        step(1, 0, 0, 0, 0, 0);
        cv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, (i % 3) != 0, 1, 5'(i + 1), 0, 0);
            cv_cnt += int'(ob_cv);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 0, 0);
            cv_cnt += int'(ob_cv);
        end
        check("wrap_count", cv_cnt, 10);

        // Mid-operation reset discards queued and in-flight words
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 5'(i + 3), 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 5'd7, 0, 0);
        check("rst_ready0", ob_a0, 0);
        check("rst_enc_rst_n", ob_rn, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0, 0);
            check("rst_lvl", ob_lvl, 0);
            check("rst_cv", ob_cv, 0);
            check("rst_enc", ob_enc, 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 64) == 0, ($urandom % 4) != 0,
                 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tns_link_scheduler.md
TNS_LINK_SCHEDULER -- requirements
Module: tns_link_scheduler

Interface
REQ-001 SHALL have parameter: DW, `BLEN05, width of one data word (one encoder datain).
REQ-002 SHALL have parameter: BURST, 2, maximum consecutive accepts granted to one requester while the other is waiting (1..8).
REQ-003 SHALL have parameter: DEPTH, 4, issue-FIFO entries (power of two, 2..16).
REQ-004 SHALL have ports (clock and reset first):
- clock  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  issue enable; 0 freezes FIFO pops.
- req0_valid  in  1  requester 0 offers a word.
- req0_data  in  DW  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid, req1_data, req1_ready  same for requester 1.
- enc_datain  out  DW  registered word driven to the shared TNS encoder.
- enc_rst_n  out  1  encoder reset, equal to ~rst (combinational).
- enc_codeout  in  15  encoder registered code output.
- code_out  out  15  enc_codeout passed through.
- code_valid  out  1  code_out carries a real word.
- code_src  out  1  requester index of the code_out word.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-005 SHALL accept at most one word per cycle; reqN_ready = grant==N AND reqN_valid AND FIFO not full; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-006 SHALL compute full from the registered occupancy only; a simultaneous pop never frees a slot for a push in the same cycle.
REQ-007 SHALL arbitrate round-robin: if only one requester is valid, it wins; if both are valid, the last winner keeps the grant until it has BURST consecutive accepts, then the grant passes to the other requester.
REQ-008 SHALL reset the burst counter to 0 when the grant changes owner or when the granted requester deasserts valid.
REQ-009 SHALL push {src, data} into the FIFO on each transfer and SHALL keep the FIFO in arrival order.
REQ-010 SHALL pop the FIFO head in any cycle where en=1 and the FIFO is non-empty; the popped data SHALL be registered onto enc_datain the next edge.
REQ-011 SHALL handle a simultaneous push and pop (non-full, non-empty FIFO) with occupancy unchanged.
REQ-012 SHALL update write/read pointers modulo DEPTH, with wrap-around and no lost or duplicated entries.
REQ-013 SHALL drive code_valid/code_src from a two-stage tag pipeline: pop at cycle t gives enc_datain at t+1, and code_valid=1 with matching code_src at t+2, aligned with enc_codeout.
REQ-014 SHALL have code_out follow enc_codeout every cycle; code_valid=0 on cycles not tied to a pop.
REQ-015 SHALL apply no backpressure from the output side; the encoder is clocked every cycle.
REQ-016 SHALL, when en=0, keep FIFO contents and arbitration running (until full) and SHALL pop nothing.

Reset
REQ-017 SHALL, while rst=1 at a clock edge, clear FIFO pointers and occupancy, set grant=0, burst counter=0, enc_datain=0, code_valid=0, code_src=0 and both tag stages to 0.
REQ-018 SHALL hold reqN_ready=0 during rst and SHALL hold enc_rst_n=0 while rst=1.
REQ-019 SHALL discard all queued and in-flight words when rst is asserted mid-operation, with no code_valid pulse afterwards for those words.

Configuration
REQ-020 SHALL support macro TNS_LINK_IDLE_HOLD_EN.
- Defined: enc_datain holds its last value on cycles with no pop.
- Undefined: enc_datain is loaded with 0 on cycles with no pop.

Verification
REQ-021 SHALL pass these directed scenarios:
- Reset then req0 sends 0x1, 0x2, en=1 -> code_valid high at cycles 3 and 4 after first accept, code_src=0, enc_datain=0x1 then 0x2.
- Both valid continuously, BURST=2 -> accept order src 0,0,1,1,0,0; code_src follows the same order.
- en=0, req0 sends 5 words, DEPTH=4 -> 4 accepted, fifo_level=4, req0_ready=0 on the 5th; en=1 -> 5th accepted only after the first pop cycle.
- Full FIFO, en=1, req1 valid -> no push in the pop cycle, push in the next cycle; fifo_level sequence 4,3,4.
- 10 words through DEPTH=4 -> pointer wrap, all 10 emerge in order, no duplicates.
- Assert rst for 1 cycle with 3 words queued -> fifo_level=0, code_valid stays 0 and enc_datain=0 (both macro settings).
